// File: rtl/bcd_pkg.sv
// ---------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the BCD (decade) counter family.
//   BCD_MAX / BCD_ZERO : digit bounds of one decade
//   state_t            : control states of the countdown timer
//   bcd_sat()          : clamps a 4-bit nibble into the legal 0..9 range
// No ports (package).
// ---------------------------------------------------------------------------
package bcd_pkg;

    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [3:0] BCD_ZERO = 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Nibbles A..F have no decimal meaning; treat them as the largest digit
    // so that a digit register can never hold an illegal code.
    function automatic logic [3:0] bcd_sat(input logic [3:0] digit);
        return (digit > BCD_MAX) ? BCD_MAX : digit;
    endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// ---------------------------------------------------------------------------
// bcd_down_digit
// One decade of the BCD down counter. Decrements when dec_in is high,
// rolling 0 -> 9 and asking the next decade up for a borrow.
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset (digit -> 0)
//   dec_in     in   decrement request for this decade
//   load       in   synchronous load of load_digit (wins over dec_in)
//   load_digit in   preset nibble, clamped to 9 on load
//   digit      out  current decade value, always 0..9
//   borrow_out out  combinational: dec_in while this decade is 0
// ---------------------------------------------------------------------------
module bcd_down_digit
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       dec_in,
    input  logic       load,
    input  logic [3:0] load_digit,
    output logic [3:0] digit,
    output logic       borrow_out
);

    // The borrow ripples combinationally to the next decade so the whole
    // multi-digit count settles within a single clock cycle.
    assign borrow_out = dec_in & (digit == BCD_ZERO);

    // Digit register: a load always takes priority over a decrement, and a
    // decrement at 0 wraps to 9 (the borrow above carries the underflow on).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit <= BCD_ZERO;
        end else if (load) begin
            digit <= bcd_sat(load_digit);
        end else if (dec_in) begin
            digit <= (digit == BCD_ZERO) ? BCD_MAX : digit - 4'd1;
        end
    end

endmodule

// File: rtl/bcd_down_counter.sv
// ---------------------------------------------------------------------------
// bcd_down_counter
// Multi-decade BCD countdown timer with parallel preset, start/stop control,
// per-cycle enable, terminal-count pulse and optional wrap-around.
// Parameters:
//   DIGITS  number of BCD decades (count is 4*DIGITS bits)
//   WRAP    0: stop at 0 and finish; 1: roll 0 -> 9..9 and keep running
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   en         in   count enable (one decrement per edge while running)
//   load       in   synchronous parallel load of load_val (aborts a run)
//   load_val   in   BCD preset, digit 0 in bits [3:0]
//   start      in   start counting from the current value
//   stop       in   halt a run, value held
//   count      out  current BCD value
//   zero       out  combinational count == 0
//   busy       out  high while running
//   done       out  one-cycle pulse when the count reaches 0 by decrement
//   borrow_out out  one-cycle pulse on a 0 -> 9..9 wrap
//   load_err   out  one-cycle pulse after a load with any digit > 9
// ---------------------------------------------------------------------------
module bcd_down_counter
    import bcd_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter int WRAP   = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  start,
    input  logic                  stop,
    output logic [4*DIGITS-1:0]   count,
    output logic                  zero,
    output logic                  busy,
    output logic                  done,
    output logic                  borrow_out,
    output logic                  load_err
);

    localparam int  W       = 4 * DIGITS;
    localparam logic WRAP_EN = (WRAP != 0);

    state_t state;
    state_t state_next;

    logic [DIGITS:0] dec_chain;
    logic            decrement;
    logic            start_take;
    logic            count_is_one;
    logic            load_bad;
    logic            done_next;

    assign zero         = (count == '0);
    assign busy         = (state == ST_RUN);
    assign count_is_one = (count == W'(1));

    // A decrement only happens in RUN with nothing of higher priority
    // present. Without wrap, RUN at zero cannot normally occur, but the
    // guard keeps the counter from ever rolling over in that configuration.
    assign decrement  = busy & en & ~load & ~stop & (WRAP_EN | ~zero);
    assign start_take = start & ~load & ~stop & (state != ST_RUN);

    assign dec_chain[0] = decrement;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_down_digit u_digit (
            .clk        (clk),
            .rst_n      (rst_n),
            .dec_in     (dec_chain[i]),
            .load       (load),
            .load_digit (load_val[4*i +: 4]),
            .digit      (count[4*i +: 4]),
            .borrow_out (dec_chain[i+1])
        );
    end

    // Flag a preset that contains any non-decimal nibble; the digits clamp
    // it themselves, this only reports that it happened.
    always_comb begin
        load_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (load_val[4*i +: 4] > BCD_MAX) begin
                load_bad = 1'b1;
            end
        end
    end

    // Next-state logic, priority load > stop > start > decrement. The done
    // pulse is raised either by the final 1 -> 0 decrement or by starting a
    // non-wrapping counter that is already at zero.
    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        if (load) begin
            state_next = ST_IDLE;
        end else if (stop) begin
            if (state == ST_RUN) begin
                state_next = ST_IDLE;
            end
        end else if (start_take) begin
            if (!zero || WRAP_EN) begin
                state_next = ST_RUN;
            end else begin
                state_next = ST_DONE;
                done_next  = 1'b1;
            end
        end else if (decrement && count_is_one) begin
            done_next = 1'b1;
            if (!WRAP_EN) begin
                state_next = ST_DONE;
            end
        end
    end

    // State register plus the three single-cycle status pulses. Each pulse
    // is recomputed every edge, so none of them can stretch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            done       <= 1'b0;
            borrow_out <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            state      <= state_next;
            done       <= done_next;
            borrow_out <= dec_chain[DIGITS];
            load_err   <= load & load_bad;
        end
    end

endmodule
